matrix_scan_driver: RTL
=======================

Name: matrix_scan_driver

Overview:
- Drives the 8x8 LED matrix that the matrix decoder path produces frames for.
- Accepts frame rows over a valid/ready write port into a back buffer, then swaps the back buffer into a front buffer on a frame boundary.
- Time-multiplexes the front buffer onto one-hot row selects and column data, with a configurable dwell time and an anti-ghosting blank interval between rows.

Parameters:
- DWELL_CYCLES, 1000: clock cycles each row is lit; must be at least 1.
- BLANK_CYCLES, 2: clock cycles all outputs are dark before each row; 0 disables blanking.
- CNT_W, 16: width of the dwell/blank counter; must satisfy 2^CNT_W > max(DWELL_CYCLES, BLANK_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  row write request.
- wr_ready  out  1  write port can accept a row.
- wr_row  in  3  row index 0..7 to write.
- wr_data  in  8  column bits for the row; bit i drives column i.
- wr_last  in  1  this write completes the frame and requests a swap.
- row_sel  out  8  one-hot active-high row enable.
- col_data  out  8  active-high column data for the selected row.
- frame_start  out  1  one-cycle pulse when row 0 begins showing.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- All outputs are registered.
- Reset (async, any time, including mid-frame):
  - row_sel=0, col_data=0, frame_start=0, wr_ready=1, swap_pending=0.
  - Front and back buffers are cleared to 0.
  - row_idx=0, counter=0, state=BLANK.
- Write port:
  - A transfer occurs on a cycle with wr_valid and wr_ready both high; back[wr_row] <= wr_data.
  - If wr_last is also high, swap_pending is set and wr_ready drops the next cycle.
  - wr_ready stays 0 while swap_pending=1.
  - Rows not written keep their previous back-buffer value.
  - Writing the same row twice: the last write wins.
- FSM states are BLANK and SHOW.
- BLANK:
  - row_sel=0 and col_data=0.
  - Stays BLANK_CYCLES cycles, then enters SHOW.
  - If BLANK_CYCLES=0, BLANK is skipped and the FSM goes directly to SHOW.
- SHOW:
  - row_sel = 1<<row_idx and col_data = front[row_idx].
  - Stays DWELL_CYCLES cycles.
  - On exit, row_idx increments and the FSM returns to BLANK, or to SHOW if BLANK_CYCLES=0.
- frame_start is high for exactly the first SHOW cycle of row 0.
- Frame boundary, at the exit of SHOW for row 7:
  - row_idx wraps to 0.
  - If swap_pending is 1 in that cycle: front <= back (all 8 rows in one cycle), swap_pending clears, and wr_ready returns to 1 the next cycle.
- Simultaneous events: a wr_last transfer in the frame-boundary cycle (possible only when swap_pending was 0) sets swap_pending. The swap then occurs at the following frame boundary, not the current one.
- Frame period is exactly 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- The displayed frame never changes mid-frame, and row_sel never has more than one bit set.
- The counter resets to 0 on every state change and never wraps within a state.

Optional Feature:
- Macro: MATRIX_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness[2:0].
  - In SHOW, col_data = front[row_idx] only for the first (brightness+1)*(DWELL_CYCLES/8) cycles of the dwell, and 0 for the remaining cycles.
  - row_sel stays asserted for the full dwell.
  - DWELL_CYCLES must be a multiple of 8.
  - brightness is sampled on entry to SHOW.
- Undefined:
  - No brightness port.
  - col_data holds for the full dwell, identical to brightness=7.

Test Plan:
- Reset (DWELL=4, BLANK=1): hold rst_n=0, then release.
  - All outputs 0 and wr_ready=1.
  - The first frame_start comes 1 cycle after release and shows row 0 with col_data=0x00.
  - Frame period is 40 cycles.
- Frame load: write rows 0..7 with 0x01,0x02,...,0x80, setting wr_last on row 7.
  - wr_ready drops to 0.
  - At the next boundary the swap occurs and wr_ready returns to 1.
  - The next frame shows row_sel=0x01/col 0x01 through row_sel=0x80/col 0x80.
- Mid-frame stability: write wr_last during row 3 of a frame.
  - The current frame continues showing old data for rows 4..7.
  - New data appears from the next frame_start.
- Boundary collision: issue a wr_last transfer exactly in the row-7 exit cycle with swap_pending=0.
  - No swap at this boundary.
  - The swap happens at the following boundary, and wr_ready stays 0 in between.
- Async reset mid-SHOW of row 5:
  - Outputs clear immediately, without waiting for a clock edge.
  - Buffers read back 0 on the next frame.
  - The scan restarts at row 0.
- MATRIX_BRIGHTNESS_EN (DWELL=16, brightness=1):
  - col_data equals row data for 4 cycles and is 0 for 12 cycles.
  - row_sel is held for all 16 cycles.

Source files
------------

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - 8x8 LED matrix scan driver with double-buffered frames
//
// Purpose: accepts frame rows into a back buffer over a valid/ready port,
// swaps the back buffer into the front buffer at a frame boundary, and scans
// the front buffer onto one-hot row selects with a blank gap between rows.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready   row write handshake
//   wr_row, wr_data     row index and its column bits
//   wr_last             final row of a frame; requests a buffer swap
//   row_sel             one-hot active-high row enable
//   col_data            active-high column data for the selected row
//   frame_start         one-cycle pulse on the first lit cycle of row 0
//   brightness          (MATRIX_BRIGHTNESS_EN only) lit eighths of the dwell minus one
//
// Optional feature macro: MATRIX_BRIGHTNESS_EN.
module matrix_scan_driver #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
`ifdef MATRIX_BRIGHTNESS_EN
  input  logic [2:0] brightness,
`endif
  output logic [7:0] row_sel,
  output logic [7:0] col_data,
  output logic       frame_start
);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       row_idx, row_d;
  logic [7:0]       front [8];
  logic [7:0]       back  [8];
  logic             swap_pending, swap_pending_d;
  logic             swap_now;
  logic             wr_fire;
  logic [7:0]       shown;
  logic [7:0]       row_sel_d, col_data_d;
  logic             frame_start_d;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [2:0]       bright_q, bright_d;
  int               lit_len;
`endif

  assign wr_fire = wr_valid & wr_ready;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    row_d    = row_idx;
    swap_now = 1'b0;
    case (state)
      ST_BLANK: begin
        if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_d    = '0;
          row_d    = row_idx + 3'd1;
          state_d  = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
          swap_now = (row_idx == 3'd7) && swap_pending;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A swap and a new wr_last can never coincide: wr_ready is low while pending.
    swap_pending_d = swap_pending;
    if (swap_now) begin
      swap_pending_d = 1'b0;
    end else if (wr_fire && wr_last) begin
      swap_pending_d = 1'b1;
    end

    // Outputs are registered, so they are derived from the next-cycle view;
    // on a swap cycle the next front buffer is the current back buffer.
    shown = swap_now ? back[row_d] : front[row_d];

    row_sel_d     = '0;
    col_data_d    = '0;
    frame_start_d = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
    bright_d = bright_q;
    if (state_d == ST_SHOW && cnt_d == '0) begin
      bright_d = brightness;
    end
    lit_len = (int'(bright_d) + 1) * (DWELL_CYCLES / 8);
`endif
    if (state_d == ST_SHOW) begin
      row_sel_d     = 8'd1 << row_d;
      col_data_d    = shown;
      frame_start_d = (row_d == 3'd0) && (cnt_d == '0);
`ifdef MATRIX_BRIGHTNESS_EN
      if (int'(cnt_d) >= lit_len) begin
        col_data_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      row_idx      <= '0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b1;
      row_sel      <= '0;
      col_data     <= '0;
      frame_start  <= 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q     <= '0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      row_idx      <= row_d;
      swap_pending <= swap_pending_d;
      wr_ready     <= ~swap_pending_d;
      row_sel      <= row_sel_d;
      col_data     <= col_data_d;
      frame_start  <= frame_start_d;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q     <= bright_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
    end else begin
      if (swap_now) begin
        for (int i = 0; i < 8; i++) begin
          front[i] <= back[i];
        end
      end
      if (wr_fire) begin
        back[wr_row] <= wr_data;
      end
    end
  end

endmodule
